// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed scan driver for a 4-digit 7-segment display.
// Takes a 28-bit frame {seg1,seg2,seg3,seg4} (active-high, bit order g..a,
// seg1 = leftmost digit) and drives shared active-low cathodes plus one
// active-low anode per digit. A new frame is double-buffered and only swapped
// in at a frame boundary, so the display never shows a torn frame.
// Each digit slot starts with a short all-anodes-off window to hide ghosting,
// and any digit can be made to blink via blink_mask.
// Optional build macro SEG7_DIM_EN adds a 3-bit brightness input driving an
// 8-step PWM on the anodes.
module seg7_scan_driver #(
  parameter int CLK_DIV      = 100000, // clk cycles per digit slot, >= 2
  parameter int BLANK_CYCLES = 16,     // blanked cycles at slot start, < CLK_DIV
  parameter int BLINK_DIV    = 128     // frames per blink-phase toggle, >= 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [27:0] seg_in,
  input  logic        seg_valid,
  input  logic [3:0]  blink_mask,
  input  logic        display_en,
`ifdef SEG7_DIM_EN
  input  logic [2:0]  brightness,
`endif
  output logic [3:0]  an,
  output logic [6:0]  cathode,
  output logic        frame_done
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int FRM_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYCLES);
  localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(BLINK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       digit;      // 0 = leftmost digit (seg1, an[3])
  logic [FRM_W-1:0] frame_cnt;
  logic             blink_phase;

  logic [27:0]      shadow;
  logic [27:0]      active;
  logic             pending;

  logic             slot_end;
  logic             frame_end;

  logic [6:0]       cur_seg;
  logic [3:0]       cur_sel;
  logic             cur_blink;
  logic             anode_on;
  logic [3:0]       an_next;
  logic [6:0]       cathode_next;

  assign slot_end  = (div_cnt == DIV_LAST);
  assign frame_end = slot_end && (digit == 2'd3);

  // Slot divider and digit scan counter.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_cnt <= '0;
      digit   <= 2'd0;
    end else if (slot_end) begin
      div_cnt <= '0;
      digit   <= digit + 2'd1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Double-buffered frame load; active only changes at a frame boundary.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else if (frame_end) begin
      // A write landing on the boundary itself goes straight to the display.
      if (seg_valid) begin
        shadow  <= seg_in;
        active  <= seg_in;
        pending <= 1'b0;
      end else if (pending) begin
        active  <= shadow;
        pending <= 1'b0;
      end
    end else if (seg_valid) begin
      shadow  <= seg_in;
      pending <= 1'b1;
    end
  end

  // Blink phase flips once every BLINK_DIV completed frames.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_end) begin
      if (frame_cnt == FRM_LAST) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

`ifdef SEG7_DIM_EN
  logic [2:0] pwm_cnt;

  // Free-running PWM counter for brightness dimming.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pwm_cnt <= 3'd0;
    end else begin
      pwm_cnt <= pwm_cnt + 3'd1;
    end
  end
`endif

  // Select the current digit's segments/anode and decide whether it is lit.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    cur_seg   = active[27:21];
    cur_sel   = 4'b0111;
    cur_blink = blink_mask[3];
    unique case (digit)
      2'd0: begin
        cur_seg   = active[27:21];
        cur_sel   = 4'b0111;
        cur_blink = blink_mask[3];
      end
      2'd1: begin
        cur_seg   = active[20:14];
        cur_sel   = 4'b1011;
        cur_blink = blink_mask[2];
      end
      2'd2: begin
        cur_seg   = active[13:7];
        cur_sel   = 4'b1101;
        cur_blink = blink_mask[1];
      end
      2'd3: begin
        cur_seg   = active[6:0];
        cur_sel   = 4'b1110;
        cur_blink = blink_mask[0];
      end
    endcase

    anode_on = display_en
            && (div_cnt >= BLANK_END)
            && !(blink_phase && cur_blink);
`ifdef SEG7_DIM_EN
    anode_on = anode_on && (pwm_cnt <= brightness);
`endif

    an_next      = anode_on ? cur_sel : 4'b1111;
    cathode_next = ~cur_seg;
  end

  // Registered outputs: one cycle behind the counter state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      an         <= 4'b1111;
      cathode    <= 7'b1111111;
      frame_done <= 1'b0;
    end else begin
      an         <= an_next;
      cathode    <= cathode_next;
      frame_done <= frame_end;
    end
  end

endmodule
